if_fetch_stage: RTL and testbench



---
 rtl/if_fetch_stage_if.sv | 37 +++
 rtl/if_fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_if_fetch_stage.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - fetch stage bundle: imem request/response, EX redirect, decode stall, IF/ID (id_pred_taken only with JAL_PREDICT_EN)
interface if_fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [31:0]     imem_rsp_data;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            stall;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [31:0]     id_instr;
`ifdef JAL_PREDICT_EN
  logic            id_pred_taken;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_pred_taken,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr, id_pred_taken,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );
`else
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_instr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, stall
  );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - RV32 fetch stage: PC, imem requests, fetch queue, IF/ID register; JAL predecode under JAL_PREDICT_EN
module if_fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              FQ_DEPTH = 2
) (
  input logic              clk,
  input logic              rstn,
  if_fetch_stage_if.master bus
);
  localparam int          CW      = $clog2(FQ_DEPTH + 1);
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(FQ_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   occ_q, occ_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;
  logic [XLEN-1:0] fq_pc_q    [FQ_DEPTH];
  logic [XLEN-1:0] fq_pc_d    [FQ_DEPTH];
  logic [31:0]     fq_instr_q [FQ_DEPTH];
  logic [31:0]     fq_instr_d [FQ_DEPTH];

  logic            req_valid, accept, rsp_take, rsp_keep, load_en;
  logic            deq, enq, bypass, fq_overflow, pred_hit;
  logic [CW-1:0]   wr_idx;
  logic            unused_redirect_lsbs;

`ifdef JAL_PREDICT_EN
  logic            id_pred_q, id_pred_d;
  logic            fq_pred_q [FQ_DEPTH];
  logic            fq_pred_d [FQ_DEPTH];
  logic [XLEN-1:0] jal_imm;
`endif

  // Request credit, response filtering, fetch queue and IF/ID next state.
  always_comb begin
    // A response is only real if something is outstanding; drop_q marks the
    // ones belonging to a fetch path that has since been redirected away.
    rsp_take = bus.imem_rsp_valid && (out_q != '0);
    rsp_keep = rsp_take && (drop_q == '0) && !bus.redirect_valid;
`ifdef JAL_PREDICT_EN
    pred_hit = rsp_keep && (bus.imem_rsp_data[6:0] == 7'b1101111);
    jal_imm  = {{(XLEN-21){bus.imem_rsp_data[31]}}, bus.imem_rsp_data[31],
                bus.imem_rsp_data[19:12], bus.imem_rsp_data[20],
                bus.imem_rsp_data[30:21], 1'b0};
`else
    pred_hit = 1'b0;
`endif
    // Queued plus in-flight words never exceed the queue size, so every
    // returning word always has a slot.
    req_valid = rstn && !bus.redirect_valid && !pred_hit &&
                (({1'b0, occ_q} + {1'b0, out_q}) < DEPTH_W);
    accept    = req_valid && bus.imem_req_ready;
    load_en   = !id_valid_q || !bus.stall;
    deq       = load_en && (occ_q != '0);
    bypass    = load_en && (occ_q == '0) && rsp_keep;
    enq       = rsp_keep && !bypass;
    wr_idx    = occ_q - CW'(deq);
    fq_overflow = enq && !deq && (occ_q == DEPTH_W[CW-1:0]);

    pc_d     = accept ? pc_q + XLEN'(4) : pc_q;
    rsp_pc_d = accept ? pc_q : rsp_pc_q;
    out_d    = out_q + CW'(accept) - CW'(rsp_take);
    drop_d   = drop_q - CW'(rsp_take && (drop_q != '0));
    occ_d    = occ_q - CW'(deq) + CW'(enq);

    for (int i = 0; i < FQ_DEPTH; i++) begin
      fq_pc_d[i]    = fq_pc_q[i];
      fq_instr_d[i] = fq_instr_q[i];
    end
    if (deq) begin
      for (int i = 0; i < FQ_DEPTH - 1; i++) begin
        fq_pc_d[i]    = fq_pc_q[i+1];
        fq_instr_d[i] = fq_instr_q[i+1];
      end
    end
    for (int i = 0; i < FQ_DEPTH; i++) begin
      if (enq && (CW'(i) == wr_idx)) begin
        fq_pc_d[i]    = rsp_pc_q;
        fq_instr_d[i] = bus.imem_rsp_data;
      end
    end

    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    if (load_en) begin
      if (deq) begin
        id_valid_d = 1'b1;
        id_pc_d    = fq_pc_q[0];
        id_instr_d = fq_instr_q[0];
      end else if (bypass) begin
        id_valid_d = 1'b1;
        id_pc_d    = rsp_pc_q;
        id_instr_d = bus.imem_rsp_data;
      end else begin
        id_valid_d = 1'b0;
      end
    end

`ifdef JAL_PREDICT_EN
    id_pred_d = id_pred_q;
    for (int i = 0; i < FQ_DEPTH; i++) fq_pred_d[i] = fq_pred_q[i];
    if (deq) begin
      for (int i = 0; i < FQ_DEPTH - 1; i++) fq_pred_d[i] = fq_pred_q[i+1];
    end
    for (int i = 0; i < FQ_DEPTH; i++) begin
      if (enq && (CW'(i) == wr_idx)) fq_pred_d[i] = pred_hit;
    end
    if (load_en) id_pred_d = deq ? fq_pred_q[0] : (bypass && pred_hit);
    // The JAL stays in the stream; everything fetched after it is wrong-path.
    if (pred_hit) begin
      pc_d   = rsp_pc_q + jal_imm;
      drop_d = out_q - CW'(1);
    end
`endif

    // EX redirect overrides stall, responses and any prediction.
    if (bus.redirect_valid) begin
      pc_d       = {bus.redirect_pc[XLEN-1:2], 2'b00};
      occ_d      = '0;
      id_valid_d = 1'b0;
      drop_d     = out_q - CW'(rsp_take);
    end
  end

  assign unused_redirect_lsbs = ^bus.redirect_pc[1:0];

  // State registers; reset clears the pipeline and forgets outstanding fetches.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= '0;
      occ_q      <= '0;
      out_q      <= '0;
      drop_q     <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_q[i]    <= '0;
        fq_instr_q[i] <= NOP;
      end
`ifdef JAL_PREDICT_EN
      id_pred_q <= 1'b0;
      for (int i = 0; i < FQ_DEPTH; i++) fq_pred_q[i] <= 1'b0;
`endif
    end else begin
      pc_q       <= pc_d;
      rsp_pc_q   <= rsp_pc_d;
      occ_q      <= occ_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      for (int i = 0; i < FQ_DEPTH; i++) begin
        fq_pc_q[i]    <= fq_pc_d[i];
        fq_instr_q[i] <= fq_instr_d[i];
      end
`ifdef JAL_PREDICT_EN
      id_pred_q <= id_pred_d;
      for (int i = 0; i < FQ_DEPTH; i++) fq_pred_q[i] <= fq_pred_d[i];
`endif
    end
  end

  // A word arriving with no free slot means the credit accounting is broken.
  assert property (@(posedge clk) disable iff (!rstn) !fq_overflow);

  assign bus.imem_req_valid = req_valid;
  assign bus.imem_req_addr  = pc_q;
  assign bus.id_valid       = id_valid_q;
  assign bus.id_pc          = id_pc_q;
  assign bus.id_instr       = id_instr_q;
`ifdef JAL_PREDICT_EN
  assign bus.id_pred_taken  = id_pred_q && id_valid_q;
`endif
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed bench for if_fetch_stage with a one-cycle-latency instruction memory
module tb_if_fetch_stage;
  logic clk;
  logic rstn;
  int   n_checks;
  int   n_pass;

  if_fetch_stage_if #(.XLEN(32)) b0 ();
  if_fetch_stage_if #(.XLEN(32)) b1 ();

  if_fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FQ_DEPTH(2)) dut0 (
    .clk(clk), .rstn(rstn), .bus(b0)
  );
  if_fetch_stage #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FQ_DEPTH(2)) dut1 (
    .clk(clk), .rstn(rstn), .bus(b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[24:0], 7'h13};
  endfunction

  // Instruction memory: answers every accepted request exactly one cycle later.
  always @(posedge clk) begin
    b0.imem_rsp_valid <= b0.imem_req_valid && b0.imem_req_ready;
    b0.imem_rsp_data  <= mem_word(b0.imem_req_addr);
    b1.imem_rsp_valid <= b1.imem_req_valid && b1.imem_req_ready;
    b1.imem_rsp_data  <= mem_word(b1.imem_req_addr);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (b0.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b expected 0", b0.imem_req_valid); else n_pass++;
    n_checks++; if (b0.id_valid !== 1'b0) $display("FAIL rst_id_valid: got %b expected 0", b0.id_valid); else n_pass++;
    n_checks++; if (b0.id_pc !== 32'h0) $display("FAIL rst_id_pc: got %h expected 0", b0.id_pc); else n_pass++;
    n_checks++; if (b0.id_instr !== 32'h13) $display("FAIL rst_id_instr: got %h expected 00000013", b0.id_instr); else n_pass++;
    n_checks++; if (b0.imem_req_addr !== 32'h0) $display("FAIL rst_addr0: got %h expected 0", b0.imem_req_addr); else n_pass++;
    n_checks++; if (b1.imem_req_addr !== 32'hFFFF_FFF8) $display("FAIL rst_addr1: got %h expected fffffff8", b1.imem_req_addr); else n_pass++;
  endtask

  task automatic test_stream;
    tick; rstn = 1'b1; #1;
    n_checks++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h0) $display("FAIL stream_req0: got %b/%h expected 1/0", b0.imem_req_valid, b0.imem_req_addr); else n_pass++;
    n_checks++; if (b0.id_valid !== 1'b0) $display("FAIL stream_idv0: got %b expected 0", b0.id_valid); else n_pass++;
    tick; #1;
    n_checks++; if (b0.imem_req_addr !== 32'h4 || b0.id_valid !== 1'b0) $display("FAIL stream_c1: got addr %h idv %b expected 4/0", b0.imem_req_addr, b0.id_valid); else n_pass++;
    tick; #1;
    n_checks++; if (b0.imem_req_addr !== 32'h8) $display("FAIL stream_addr8: got %h expected 8", b0.imem_req_addr); else n_pass++;
    n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h0 || b0.id_instr !== mem_word(32'h0)) $display("FAIL stream_first: got %b/%h/%h expected 1/0/%h", b0.id_valid, b0.id_pc, b0.id_instr, mem_word(32'h0)); else n_pass++;
    for (int k = 1; k <= 3; k++) begin
      tick; #1;
      n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'(4*k) || b0.id_instr !== mem_word(32'(4*k))) $display("FAIL stream_seq: got %b/%h expected 1/%h", b0.id_valid, b0.id_pc, 32'(4*k)); else n_pass++;
    end
  endtask

  task automatic test_stall;
    tick; b0.stall = 1'b1; #1;
    n_checks++; if (b0.id_pc !== 32'h10 || b0.imem_req_addr !== 32'h18 || b0.imem_req_valid !== 1'b1) $display("FAIL stall_enter: got %h/%h/%b expected 10/18/1", b0.id_pc, b0.imem_req_addr, b0.imem_req_valid); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick; #1;
      n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h10 || b0.id_instr !== mem_word(32'h10)) $display("FAIL stall_hold: got %b/%h expected 1/10", b0.id_valid, b0.id_pc); else n_pass++;
      n_checks++; if (b0.imem_req_valid !== 1'b0) $display("FAIL stall_credit: got %b expected 0", b0.imem_req_valid); else n_pass++;
    end
    tick; b0.stall = 1'b0; #1;
    n_checks++; if (b0.id_pc !== 32'h10 || b0.imem_req_valid !== 1'b0) $display("FAIL stall_release: got %h/%b expected 10/0", b0.id_pc, b0.imem_req_valid); else n_pass++;
    for (int k = 1; k <= 4; k++) begin
      tick; #1;
      n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'(32'h10 + 4*k)) $display("FAIL stall_resume: got %b/%h expected 1/%h", b0.id_valid, b0.id_pc, 32'(32'h10 + 4*k)); else n_pass++;
      if (k == 1) begin
        n_checks++; if (b0.imem_req_addr !== 32'h1C || b0.imem_req_valid !== 1'b1) $display("FAIL stall_refill: got %h/%b expected 1c/1", b0.imem_req_addr, b0.imem_req_valid); else n_pass++;
      end
    end
  endtask

  task automatic test_redirect;
    tick; b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h100; #1;
    n_checks++; if (b0.imem_req_valid !== 1'b0) $display("FAIL redir_req_n: got %b expected 0", b0.imem_req_valid); else n_pass++;
    tick; b0.redirect_valid = 1'b0; #1;
    n_checks++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h100) $display("FAIL redir_target: got %b/%h expected 1/100", b0.imem_req_valid, b0.imem_req_addr); else n_pass++;
    n_checks++; if (b0.id_valid !== 1'b0) $display("FAIL redir_flush: got %b expected 0", b0.id_valid); else n_pass++;
    tick; #1;
    n_checks++; if (b0.id_valid !== 1'b0 || b0.imem_req_addr !== 32'h104) $display("FAIL redir_n2: got %b/%h expected 0/104", b0.id_valid, b0.imem_req_addr); else n_pass++;
    tick; #1;
    n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h100 || b0.id_instr !== mem_word(32'h100)) $display("FAIL redir_first: got %b/%h/%h expected 1/100/%h", b0.id_valid, b0.id_pc, b0.id_instr, mem_word(32'h100)); else n_pass++;
    tick; #1;
    n_checks++; if (b0.id_pc !== 32'h104) $display("FAIL redir_next: got %h expected 104", b0.id_pc); else n_pass++;
  endtask

  task automatic test_redirect_stall;
    tick; b0.redirect_valid = 1'b1; b0.redirect_pc = 32'h103; b0.stall = 1'b1; #1;
    n_checks++; if (b0.imem_req_valid !== 1'b0) $display("FAIL rs_req: got %b expected 0", b0.imem_req_valid); else n_pass++;
    tick; b0.redirect_valid = 1'b0; #1;
    n_checks++; if (b0.id_valid !== 1'b0) $display("FAIL rs_flush: got %b expected 0", b0.id_valid); else n_pass++;
    n_checks++; if (b0.imem_req_addr !== 32'h100 || b0.imem_req_valid !== 1'b1) $display("FAIL rs_align: got %h/%b expected 100/1", b0.imem_req_addr, b0.imem_req_valid); else n_pass++;
    tick; b0.stall = 1'b0; #1;
    n_checks++; if (b0.id_valid !== 1'b0) $display("FAIL rs_gap: got %b expected 0", b0.id_valid); else n_pass++;
    tick; #1;
    n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h100) $display("FAIL rs_resume: got %b/%h expected 1/100", b0.id_valid, b0.id_pc); else n_pass++;
  endtask

  task automatic test_wrap;
    tick; b1.imem_req_ready = 1'b1; #1;
    n_checks++; if (b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'hFFFF_FFF8) $display("FAIL wrap_c0: got %b/%h expected 1/fffffff8", b1.imem_req_valid, b1.imem_req_addr); else n_pass++;
    tick; b1.imem_req_ready = 1'b0; #1;
    n_checks++; if (b1.imem_req_valid !== 1'b1 || b1.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_c1: got %b/%h expected 1/fffffffc", b1.imem_req_valid, b1.imem_req_addr); else n_pass++;
    tick; #1;
    n_checks++; if (b1.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_hold: got %h expected fffffffc", b1.imem_req_addr); else n_pass++;
    n_checks++; if (b1.id_valid !== 1'b1 || b1.id_pc !== 32'hFFFF_FFF8 || b1.id_instr !== mem_word(32'hFFFF_FFF8)) $display("FAIL wrap_id0: got %b/%h expected 1/fffffff8", b1.id_valid, b1.id_pc); else n_pass++;
    tick; b1.imem_req_ready = 1'b1; #1;
    n_checks++; if (b1.imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_c3: got %h expected fffffffc", b1.imem_req_addr); else n_pass++;
    tick; #1;
    n_checks++; if (b1.imem_req_addr !== 32'h0 || b1.imem_req_valid !== 1'b1) $display("FAIL wrap_zero: got %h/%b expected 0/1", b1.imem_req_addr, b1.imem_req_valid); else n_pass++;
    tick; #1;
    n_checks++; if (b1.id_valid !== 1'b1 || b1.id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_id1: got %b/%h expected 1/fffffffc", b1.id_valid, b1.id_pc); else n_pass++;
    tick; #1;
    n_checks++; if (b1.id_valid !== 1'b1 || b1.id_pc !== 32'h0) $display("FAIL wrap_id2: got %b/%h expected 1/0", b1.id_valid, b1.id_pc); else n_pass++;
  endtask

  task automatic test_mid_reset;
    tick; #1;
    n_checks++; if (b0.id_valid !== 1'b1) $display("FAIL mr_pre: got %b expected 1", b0.id_valid); else n_pass++;
    rstn = 1'b0; #1;
    n_checks++; if (b0.id_instr !== 32'h13 || b0.id_valid !== 1'b0 || b0.id_pc !== 32'h0) $display("FAIL mr_async: got %b/%h/%h expected 0/0/00000013", b0.id_valid, b0.id_pc, b0.id_instr); else n_pass++;
    n_checks++; if (b0.imem_req_valid !== 1'b0 || b0.imem_req_addr !== 32'h0) $display("FAIL mr_req: got %b/%h expected 0/0", b0.imem_req_valid, b0.imem_req_addr); else n_pass++;
    #1; rstn = 1'b1; #1;
    n_checks++; if (b0.imem_req_valid !== 1'b1 || b0.imem_req_addr !== 32'h0) $display("FAIL mr_refetch: got %b/%h expected 1/0", b0.imem_req_valid, b0.imem_req_addr); else n_pass++;
    tick; #1;
    n_checks++; if (b0.id_valid !== 1'b0 || b0.imem_req_addr !== 32'h4) $display("FAIL mr_stale: got %b/%h expected 0/4", b0.id_valid, b0.imem_req_addr); else n_pass++;
    tick; #1;
    n_checks++; if (b0.id_valid !== 1'b1 || b0.id_pc !== 32'h0 || b0.id_instr !== mem_word(32'h0)) $display("FAIL mr_first: got %b/%h/%h expected 1/0/%h", b0.id_valid, b0.id_pc, b0.id_instr, mem_word(32'h0)); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rstn = 1'b0;
    b0.imem_req_ready = 1'b1; b0.redirect_valid = 1'b0; b0.redirect_pc = 32'h0; b0.stall = 1'b0;
    b1.imem_req_ready = 1'b0; b1.redirect_valid = 1'b0; b1.redirect_pc = 32'h0; b1.stall = 1'b0;
    test_reset;
    test_stream;
    test_stall;
    test_redirect;
    test_redirect_stall;
    test_wrap;
    test_mid_reset;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
